mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Single-port RAM access controller and arbiter.
- Shares one data RAM between the IF-stage fetch requester and the MEM-stage load/store requester.
- Sequences each access through a fixed-latency RAM and generates byte-lane write enables for stores.
- Returns the raw aligned 32-bit word; WB performs lane selection and sign extension. Raises a pipeline stall while any request is outstanding.

Parameters:
- LATENCY, 1: cycles from the ram_en cycle to valid ram_rdata. Legal range 1..15.
- CNT_W, 4: width of the latency counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request; held until inst_ready
- inst_addr  in  32  fetch byte address; [1:0] ignored
- inst_rdata  out  32  fetched word; valid while inst_ready
- inst_ready  out  1  one-cycle completion pulse, fetch
- data_req  in  1  load/store request; held until data_ready
- data_we  in  1  1 = store, 0 = load
- data_sel  in  4  access size: 4'b0001 byte, 4'b1111 word
- data_addr  in  32  load/store byte address
- data_wdata  in  32  store data, right-aligned
- data_rdata  out  32  raw aligned RAM word; valid while data_ready
- data_ready  out  1  one-cycle completion pulse, data
- data_err  out  1  high with data_ready when the access was rejected
- ram_en  out  1  RAM access strobe
- ram_we  out  4  RAM byte write enables
- ram_addr  out  32  word-aligned address, {addr[31:2], 2'b00}
- ram_wdata  out  32  lane-replicated write data
- ram_rdata  in  32  RAM read data, valid LATENCY cycles after ram_en
- stall_req  out  1  pipeline stall request

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE.
  - All registered outputs clear to 0: ready pulses, rdata, data_err, ram_en, ram_we, ram_addr, ram_wdata.
  - An in-flight RAM response is discarded; no ready pulse is issued for it.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Arbitration uses fixed priority: data_req beats inst_req, because the MEM instruction is older.
  - The winner's addr, we, sel and wdata are latched, along with a grant bit (D or I). Next state is ACCESS.
  - With no request, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - ram_en = 1 and ram_addr is driven. Counter loads LATENCY-1. Next state is WAIT.
  - Byte store: ram_we = 4'b0001 << addr[1:0]; ram_wdata = {4{wdata[7:0]}}.
  - Word store with addr[1:0] = 00: ram_we = 4'b1111; ram_wdata = wdata.
  - Loads and fetches: ram_we = 0.
- Rejected data access (word with addr[1:0] != 00, or sel not 0001/1111):
  - ram_en = 0 and ram_we = 0 in ACCESS.
  - Completes with data_err = 1 and data_rdata = 0.
- WAIT:
  - When counter = 0, ram_rdata is captured into the granted requester's rdata register and state goes to RESP.
  - Otherwise the counter decrements.
  - The capture cycle is the ACCESS cycle + LATENCY.
- RESP (1 cycle):
  - The granted requester's ready = 1; rdata holds the captured word. Next state is IDLE.
  - For stores, data_rdata = 0.
- Latency: a request sampled in IDLE at cycle T gives ready at cycle T+LATENCY+2. With LATENCY = 1, that is T+3.
- Back-to-back requests:
  - RESP always returns to IDLE.
  - A req still high in IDLE after RESP is treated as a new request.
  - Requesters must drop or replace req in the cycle after ready.
- Starvation: with both requests pending, data is served first and fetch immediately after. Fetch starvation cannot occur because the MEM stage waits for each access.
- Dropped requests: if req falls mid-transaction, the transaction still completes. The RAM write happens and the ready pulse is issued.
- stall_req is combinational: (data_req & ~data_ready) | (inst_req & ~inst_ready).
- Only one of inst_ready / data_ready is ever high in a given cycle.

Decomposition:
- The shared bus.v/defines file holds:
  - MEM_SEL_BYTE = 4'b0001 and MEM_SEL_WORD = 4'b1111.
  - The existing DATA_BUS, ADDR_BUS and MEM_SEL_BUS widths.
  - FSM state encodings: IDLE 2'd0, ACCESS 2'd1, WAIT 2'd2, RESP 2'd3.
- One combinational sub-module, mem_store_lane, maps (sel, addr[1:0], wdata, we) to (ram_we, ram_wdata, err). It is reused by any future store path.

Test Plan:
- Fetch only: LATENCY = 1, inst_req = 1, inst_addr = 0x0000_0104, ram_rdata = 0x2408_0005 → ram_addr = 0x104 in ACCESS, inst_ready at T+3, inst_rdata = 0x2408_0005, stall_req high T..T+2.
- Byte store: data_we = 1, data_sel = 0001, data_addr = 0x0000_0203, data_wdata = 0x0000_00AB → ram_we = 1000, ram_wdata = 0xABAB_ABAB, ram_addr = 0x200, data_ready at T+3.
- Conflict: inst_req and data_req (load, 0x300) rise together → data served first (ready T+3); fetch ram_en at T+5, inst_ready at T+7.
- Misaligned word load: addr = 0x0000_0302, sel = 1111 → ram_en never asserted, data_ready with data_err = 1, data_rdata = 0.
- LATENCY = 3: word load from 0x400 → capture exactly 3 cycles after ram_en, data_ready at T+5.
- Reset mid-WAIT: rst = 1 during WAIT → next cycle IDLE with all outputs 0 and no ready pulse; a new request after rst falls completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
// Shared bus widths, access-size encodings, FSM state encodings and the
// latched-grant record used by the RAM access controller and its store-lane
// helper.
package mem_access_ctrl_pkg;

    localparam int DATA_BUS    = 32;
    localparam int ADDR_BUS    = 32;
    localparam int MEM_SEL_BUS = 4;

    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_BYTE = 4'b0001;
    localparam logic [MEM_SEL_BUS-1:0] MEM_SEL_WORD = 4'b1111;

    // Legacy-compatible FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // What must survive from arbitration until the response is returned
    typedef struct packed {
        grant_e grant;
        logic   we;
        logic   err;
    } req_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Bundles the fetch port, the load/store port, the RAM port and the stall
// request of the access controller.
//   slave  : the controller's view (requests and ram_rdata in, rest out)
//   master : the pipeline/RAM environment's view (mirror of slave)
interface mem_access_ctrl_if;
    import mem_access_ctrl_pkg::*;

    logic                   inst_req;
    logic [ADDR_BUS-1:0]    inst_addr;
    logic [DATA_BUS-1:0]    inst_rdata;
    logic                   inst_ready;

    logic                   data_req;
    logic                   data_we;
    logic [MEM_SEL_BUS-1:0] data_sel;
    logic [ADDR_BUS-1:0]    data_addr;
    logic [DATA_BUS-1:0]    data_wdata;
    logic [DATA_BUS-1:0]    data_rdata;
    logic                   data_ready;
    logic                   data_err;

    logic                   ram_en;
    logic [3:0]             ram_we;
    logic [ADDR_BUS-1:0]    ram_addr;
    logic [DATA_BUS-1:0]    ram_wdata;
    logic [DATA_BUS-1:0]    ram_rdata;

    logic                   stall_req;

    modport slave (
        input  inst_req, inst_addr,
        output inst_rdata, inst_ready,
        input  data_req, data_we, data_sel, data_addr, data_wdata,
        output data_rdata, data_ready, data_err,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output stall_req
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_rdata, inst_ready,
        output data_req, data_we, data_sel, data_addr, data_wdata,
        input  data_rdata, data_ready, data_err,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  stall_req
    );

endinterface

// File: rtl/mem_access_ctrl_store_lane.sv
// mem_store_lane
// Combinational store-lane mapper: turns an access size, the byte offset and
// right-aligned store data into RAM byte enables and lane-replicated data,
// and flags accesses the RAM cannot perform.
//   sel       in  access size (byte / word)
//   addr_lo   in  byte offset within the word
//   wdata     in  right-aligned store data
//   we        in  1 = store
//   ram_we    out byte write enables (0 for loads)
//   ram_wdata out data placed on every lane it may land in
//   err       out misaligned word or unsupported size
module mem_store_lane
    import mem_access_ctrl_pkg::*;
(
    input  logic [MEM_SEL_BUS-1:0] sel,
    input  logic [1:0]             addr_lo,
    input  logic [DATA_BUS-1:0]    wdata,
    input  logic                   we,
    output logic [3:0]             ram_we,
    output logic [DATA_BUS-1:0]    ram_wdata,
    output logic                   err
);

    // A byte is replicated on all lanes so only the enable picks the lane
    always_comb begin
        ram_we    = 4'b0000;
        ram_wdata = wdata;
        err       = 1'b0;
        if (sel == MEM_SEL_BYTE) begin
            ram_wdata = {4{wdata[7:0]}};
            if (we) begin
                ram_we = 4'b0001 << addr_lo;
            end
        end else if (sel == MEM_SEL_WORD) begin
            if (addr_lo != 2'b00) begin
                err = 1'b1;
            end else if (we) begin
                ram_we = 4'b1111;
            end
        end else begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Arbitrates the IF fetch port and the MEM load/store port onto one
// fixed-latency single-port RAM. Returns the raw aligned word; lane selection
// and sign extension are left to WB.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch, load/store and RAM signals plus stall_req
//   LATENCY  : cycles from ram_en to valid ram_rdata (1..15)
//   CNT_W    : latency counter width
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus
);

    logic [1:0]          state_q, state_d;
    req_t                req_q, req_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ram_en_q, ram_en_d;
    logic [3:0]          ram_we_q, ram_we_d;
    logic [ADDR_BUS-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_BUS-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_BUS-1:0] inst_rdata_q, inst_rdata_d;
    logic                inst_ready_q, inst_ready_d;
    logic [DATA_BUS-1:0] data_rdata_q, data_rdata_d;
    logic                data_ready_q, data_ready_d;
    logic                data_err_q, data_err_d;

    logic                   win_data;
    logic                   win_we;
    logic [MEM_SEL_BUS-1:0] win_sel;
    logic [ADDR_BUS-1:0]    win_addr;
    logic [3:0]             lane_we;
    logic [DATA_BUS-1:0]    lane_wdata;
    logic                   lane_err;

    // Data beats fetch: the MEM-stage instruction is older. A fetch is
    // presented as an aligned word load so it can never be rejected.
    always_comb begin
        win_data = bus.data_req;
        win_we   = bus.data_req & bus.data_we;
        win_sel  = bus.data_req ? bus.data_sel  : MEM_SEL_WORD;
        win_addr = bus.data_req ? bus.data_addr : (bus.inst_addr & ~32'h3);
    end

    mem_store_lane u_store_lane (
        .sel       (win_sel),
        .addr_lo   (win_addr[1:0]),
        .wdata     (bus.data_wdata),
        .we        (win_we),
        .ram_we    (lane_we),
        .ram_wdata (lane_wdata),
        .err       (lane_err)
    );

    // RAM strobes are computed at arbitration so they are registered and
    // present for exactly the ACCESS cycle. Ready pulses default low so they
    // last one cycle.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        ram_en_d     = ram_en_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        inst_rdata_d = inst_rdata_q;
        inst_ready_d = 1'b0;
        data_rdata_d = data_rdata_q;
        data_ready_d = 1'b0;
        data_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.data_req || bus.inst_req) begin
                    req_d.grant = win_data ? GRANT_D : GRANT_I;
                    req_d.we    = win_we;
                    req_d.err   = lane_err;
                    ram_en_d    = ~lane_err;
                    ram_we_d    = lane_err ? 4'b0000 : lane_we;
                    ram_addr_d  = {win_addr[ADDR_BUS-1:2], 2'b00};
                    ram_wdata_d = lane_wdata;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_en_d = 1'b0;
                ram_we_d = 4'b0000;
                cnt_d    = CNT_W'(LATENCY - 1);
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (req_q.grant == GRANT_D) begin
                        data_rdata_d = (req_q.err || req_q.we) ? '0 : bus.ram_rdata;
                        data_ready_d = 1'b1;
                        data_err_d   = req_q.err;
                    end else begin
                        inst_rdata_d = bus.ram_rdata;
                        inst_ready_d = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset drops any in-flight access; its response is never reported
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 4'b0000;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            inst_rdata_q <= '0;
            inst_ready_q <= 1'b0;
            data_rdata_q <= '0;
            data_ready_q <= 1'b0;
            data_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            inst_ready_q <= inst_ready_d;
            data_rdata_q <= data_rdata_d;
            data_ready_q <= data_ready_d;
            data_err_q   <= data_err_d;
        end
    end

    assign bus.inst_rdata = inst_rdata_q;
    assign bus.inst_ready = inst_ready_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.data_ready = data_ready_q;
    assign bus.data_err   = data_err_q;
    assign bus.ram_en     = ram_en_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;

    // Combinational so the pipeline freezes in the same cycle a request rises
    assign bus.stall_req = (bus.data_req & ~data_ready_q) | (bus.inst_req & ~inst_ready_q);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Drives fetch and load/store requests at the controller, models the RAM
// behaviourally and checks RAM strobes and responses against a word-array
// reference memory through scoreboard queues.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.LATENCY(LAT), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_data;
        bit          err;
        logic [31:0] rdata;
        int          due;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        bit          chk_wdata;
        int          due;
    } ramx_t;

    resp_t       resp_q[$];
    ramx_t       ramx_q[$];
    logic [31:0] ref_mem[512];
    logic [31:0] ram_mem[512];
    logic        pipe_v[LAT];
    logic [31:0] pipe_d[LAT];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    // RAM: ram_rdata carries the addressed word LAT cycles after the strobe,
    // and noise at every other time
    initial begin
        bit          v;
        int          idx;
        logic [31:0] rd;
        for (int i = 0; i < LAT; i++) pipe_v[i] = 1'b0;
        bus.ram_rdata = $urandom;
        forever begin
            @(posedge clk);
            v   = (bus.ram_en === 1'b1);
            idx = int'(bus.ram_addr[10:2]);
            rd  = ram_mem[idx];
            if (v) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.ram_we[b]) ram_mem[idx][8*b +: 8] = bus.ram_wdata[8*b +: 8];
                end
            end
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_d[i] = pipe_d[i-1];
            end
            pipe_v[0] = v;
            pipe_d[0] = rd;
            #1;
            bus.ram_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : $urandom;
        end
    end

    // Monitor: compares whatever the DUT presents against the queues
    initial begin
        resp_t e;
        ramx_t r;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (bus.ram_en === 1'b1) begin
                    if (ramx_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL unexpected_ram_en: got addr %h, expected no access (cycle %0d)", bus.ram_addr, cyc);
                    end else begin
                        r = ramx_q.pop_front();
                        checkOutput("ram_en_cycle", cyc, r.due);
                        checkOutput("ram_addr", bus.ram_addr, r.addr);
                        checkOutput("ram_we", {28'b0, bus.ram_we}, {28'b0, r.we});
                        if (r.chk_wdata) checkOutput("ram_wdata", bus.ram_wdata, r.wdata);
                    end
                end else begin
                    checkOutput("ram_we_idle", {28'b0, bus.ram_we}, 32'h0);
                end
                if (bus.inst_ready === 1'b1 || bus.data_ready === 1'b1) begin
                    checkOutput("one_ready", {31'b0, bus.inst_ready & bus.data_ready}, 32'h0);
                    if (resp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL unexpected_ready: got inst %b data %b, expected none (cycle %0d)", bus.inst_ready, bus.data_ready, cyc);
                    end else begin
                        e = resp_q.pop_front();
                        checkOutput("ready_cycle", cyc, e.due);
                        checkOutput("ready_port", {30'b0, bus.data_ready, bus.inst_ready}, e.is_data ? 32'h2 : 32'h1);
                        if (e.is_data) begin
                            checkOutput("data_rdata", bus.data_rdata, e.rdata);
                            checkOutput("data_err", {31'b0, bus.data_err}, {31'b0, e.err});
                        end else begin
                            checkOutput("inst_rdata", bus.inst_rdata, e.rdata);
                        end
                    end
                end else begin
                    checkOutput("data_err_idle", {31'b0, bus.data_err}, 32'h0);
                end
                checkOutput("stall_req", {31'b0, bus.stall_req},
                            {31'b0, (bus.data_req & ~bus.data_ready) | (bus.inst_req & ~bus.inst_ready)});
            end
        end
    end

    // Reference for a load/store: legality, RAM strobe and returned word
    task automatic modelData(input logic dwe, input logic [3:0] dsel, input logic [31:0] daddr,
                             input logic [31:0] dwdata, input int ram_due, input int rdy_due);
        bit    legal;
        int    idx;
        int    lane;
        ramx_t r;
        resp_t e;
        legal = (dsel == MEM_SEL_BYTE) || (dsel == MEM_SEL_WORD && daddr[1:0] == 2'b00);
        idx   = int'(daddr[10:2]);
        lane  = int'(daddr[1:0]);
        if (legal) begin
            r.addr      = {daddr[31:2], 2'b00};
            r.due       = ram_due;
            r.chk_wdata = dwe;
            r.we        = 4'b0000;
            r.wdata     = 32'h0;
            if (dwe && dsel == MEM_SEL_BYTE) begin
                r.we    = 4'b0001 << lane;
                r.wdata = {4{dwdata[7:0]}};
                ref_mem[idx][8*lane +: 8] = dwdata[7:0];
            end else if (dwe) begin
                r.we         = 4'b1111;
                r.wdata      = dwdata;
                ref_mem[idx] = dwdata;
            end
            ramx_q.push_back(r);
        end
        e.is_data = 1'b1;
        e.err     = !legal;
        e.rdata   = (!legal || dwe) ? 32'h0 : ref_mem[idx];
        e.due     = rdy_due;
        resp_q.push_back(e);
    endtask

    task automatic modelInst(input logic [31:0] iaddr, input int ram_due, input int rdy_due);
        ramx_t r;
        resp_t e;
        r.addr      = {iaddr[31:2], 2'b00};
        r.we        = 4'b0000;
        r.wdata     = 32'h0;
        r.chk_wdata = 1'b0;
        r.due       = ram_due;
        ramx_q.push_back(r);
        e.is_data = 1'b0;
        e.err     = 1'b0;
        e.rdata   = ref_mem[int'(iaddr[10:2])];
        e.due     = rdy_due;
        resp_q.push_back(e);
    endtask

    // kind: 0 fetch, 1 load/store, 2 both raised together
    task automatic applyStimulus(input int kind, input logic [31:0] iaddr, input logic dwe,
                                 input logic [3:0] dsel, input logic [31:0] daddr,
                                 input logic [31:0] dwdata, input bit drop_mid);
        int c;
        int n;
        bit want_d, want_i, got_d, got_i;
        c      = cyc;
        want_d = (kind != 0);
        want_i = (kind != 1);
        if (want_d) modelData(dwe, dsel, daddr, dwdata, c + 1, c + LAT + 2);
        if (want_i) modelInst(iaddr, want_d ? c + LAT + 4 : c + 1, want_d ? c + 2*LAT + 5 : c + LAT + 2);
        bus.data_req   = want_d;
        bus.data_we    = dwe;
        bus.data_sel   = dsel;
        bus.data_addr  = daddr;
        bus.data_wdata = dwdata;
        bus.inst_req   = want_i;
        bus.inst_addr  = iaddr;
        got_d = !want_d;
        got_i = !want_i;
        n     = 0;
        while (!(got_d && got_i) && n < 4*LAT + 20) begin
            nextCycle();
            n++;
            if (drop_mid && n == 2 && kind != 2) begin
                bus.data_req   = 1'b0;
                bus.inst_req   = 1'b0;
                bus.data_addr  = $urandom;
                bus.data_wdata = $urandom;
                bus.inst_addr  = $urandom;
            end
            if (bus.data_ready === 1'b1 && !got_d) begin
                got_d          = 1'b1;
                bus.data_req   = 1'b0;
                bus.data_addr  = $urandom;
                bus.data_wdata = $urandom;
            end
            if (bus.inst_ready === 1'b1 && !got_i) begin
                got_i        = 1'b1;
                bus.inst_req = 1'b0;
            end
        end
        if (!(got_d && got_i)) begin
            checks++;
            fails++;
            $display("[TB] FAIL ready_timeout: got data %b inst %b, expected both done (cycle %0d)", got_d, got_i, cyc);
            bus.data_req = 1'b0;
            bus.inst_req = 1'b0;
        end
        repeat (1 + $urandom_range(0, 2)) nextCycle();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_inst_ready"}, {31'b0, bus.inst_ready}, 32'h0);
        checkOutput({tag, "_data_ready"}, {31'b0, bus.data_ready}, 32'h0);
        checkOutput({tag, "_data_err"},   {31'b0, bus.data_err},   32'h0);
        checkOutput({tag, "_inst_rdata"}, bus.inst_rdata,          32'h0);
        checkOutput({tag, "_data_rdata"}, bus.data_rdata,          32'h0);
        checkOutput({tag, "_ram_en"},     {31'b0, bus.ram_en},     32'h0);
        checkOutput({tag, "_ram_we"},     {28'b0, bus.ram_we},     32'h0);
        checkOutput({tag, "_ram_addr"},   bus.ram_addr,            32'h0);
        checkOutput({tag, "_ram_wdata"},  bus.ram_wdata,           32'h0);
    endtask

    // Reset while the load sits in WAIT; its ram strobe is still expected
    task automatic resetMidWait();
        int    c;
        ramx_t r;
        c           = cyc;
        r.addr      = 32'h400;
        r.we        = 4'b0000;
        r.wdata     = 32'h0;
        r.chk_wdata = 1'b0;
        r.due       = c + 1;
        ramx_q.push_back(r);
        bus.data_req  = 1'b1;
        bus.data_we   = 1'b0;
        bus.data_sel  = MEM_SEL_WORD;
        bus.data_addr = 32'h400;
        while (cyc < c + 2) nextCycle();
        rst          = 1'b1;
        bus.data_req = 1'b0;
        nextCycle();
        checkResetOutputs("mid_wait");
        nextCycle();
        rst = 1'b0;
        repeat (2*LAT + 4) nextCycle();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w, ia, da;
        logic [3:0]  sel;
        int          r;
        for (int i = 0; i < 512; i++) begin
            w          = $urandom;
            ref_mem[i] = w;
            ram_mem[i] = w;
        end
        ref_mem[65] = 32'h2408_0005;
        ram_mem[65] = 32'h2408_0005;

        rst            = 1'b1;
        bus.inst_req   = 1'b0;
        bus.inst_addr  = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_sel   = 4'b0000;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
        repeat (3) nextCycle();
        checkResetOutputs("reset");
        checkOutput("reset_stall", {31'b0, bus.stall_req}, 32'h0);
        rst = 1'b0;
        nextCycle();

        $display("[TB] directed accesses");
        applyStimulus(0, 32'h0000_0104, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
        applyStimulus(1, 32'h0, 1'b1, MEM_SEL_BYTE, 32'h0000_0203, 32'h0000_00AB, 1'b0);
        applyStimulus(1, 32'h0, 1'b0, MEM_SEL_WORD, 32'h0000_0200, 32'h0, 1'b0);
        applyStimulus(2, 32'h0000_0108, 1'b0, MEM_SEL_WORD, 32'h0000_0300, 32'h0, 1'b0);
        applyStimulus(1, 32'h0, 1'b0, MEM_SEL_WORD, 32'h0000_0302, 32'h0, 1'b0);
        applyStimulus(1, 32'h0, 1'b0, MEM_SEL_WORD, 32'h0000_0400, 32'h0, 1'b0);
        applyStimulus(1, 32'h0, 1'b1, MEM_SEL_WORD, 32'h0000_0500, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1, 32'h0, 1'b1, MEM_SEL_BYTE, 32'h0000_0501, 32'h0000_0077, 1'b1);
        applyStimulus(2, 32'h0000_0500, 1'b0, MEM_SEL_BYTE, 32'h0000_0502, 32'h0, 1'b0);
        applyStimulus(1, 32'h0, 1'b1, 4'b0011, 32'h0000_0504, 32'h1234_5678, 1'b0);

        $display("[TB] random accesses");
        for (int k = 0; k < 60; k++) begin
            r   = $urandom_range(0, 7);
            sel = (r < 4) ? MEM_SEL_BYTE : (r < 7) ? MEM_SEL_WORD : 4'b0011;
            da  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : $urandom_range(0, 2047);
            if (sel == MEM_SEL_WORD && $urandom_range(0, 3) != 0) da[1:0] = 2'b00;
            ia  = $urandom_range(0, 2047);
            applyStimulus($urandom_range(0, 2), ia, 1'($urandom_range(0, 1)), sel, da, $urandom,
                          $urandom_range(0, 4) == 0);
        end

        $display("[TB] reset during wait");
        applyStimulus(1, 32'h0, 1'b0, MEM_SEL_WORD, 32'h0000_0400, 32'h0, 1'b0);
        resetMidWait();
        applyStimulus(1, 32'h0, 1'b0, MEM_SEL_WORD, 32'h0000_0500, 32'h0, 1'b0);
        applyStimulus(0, 32'h0000_0106, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);

        repeat (4) nextCycle();
        checkOutput("resp_queue_drained", resp_q.size(), 32'h0);
        checkOutput("ram_queue_drained", ramx_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
